// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = producer/consumer side, slave = the subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, busy
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one full-subtractor
// cell, one bit per clock LSB first, valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_q;
  logic [CW-1:0]    cnt;
  logic             br, bout_q, ov_q, busy_q, rdy_q;
  logic             a, b, diff, br_nx;

  always_comb begin
    a     = a_sh[0];
    b     = b_sh[0];
    diff  = a ^ b ^ br;
    br_nx = (~a & b) | (~(a ^ b) & br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      d_q    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          a_sh   <= bus.A;
          b_sh   <= bus.B;
          br     <= bus.Bin;
          d_sh   <= '0;
          cnt    <= '0;
          busy_q <= 1'b1;
          rdy_q  <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nx;
          d_sh <= {diff, d_sh[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // Result register is loaded only here so it survives the next accept.
          if (cnt == CW'(WIDTH - 1)) begin
            d_q    <= {diff, d_sh[WIDTH-1:1]};
            bout_q <= br_nx;
            ov_q   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          ov_q   <= 1'b0;
          busy_q <= 1'b0;
          rdy_q  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q & ~rst;
  assign bus.out_valid = ov_q;
  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors plus an
// exhaustive sweep scored against an arithmetic reference queue.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0, n_res = 0;
  logic rnd_en = 1'b0, ordy_fix = 1'b1;
  logic [W:0] exp_q[$];
  logic prev_ov = 1'b0, prev_hold = 1'b0;
  logic [W:0] prev_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready: fixed level or random backpressure.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_en ? 1'($urandom_range(0, 1)) : ordy_fix;
  end

  // Reference model + scoreboard; every output observation goes through here.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({1'b0, bus.A} - {1'b0, bus.B} - (W+1)'(bus.Bin));
        acc_cyc = cyc + 1;
        n_acc++;
      end
      if (bus.out_valid && !prev_ov) begin
        check("latency", cyc - acc_cyc, W);
        check("valid_without_op", exp_q.size() > 0, 1);
      end
      if (prev_hold)
        check("hold_stable", {bus.out_valid, bus.Bout, bus.D}, {1'b1, prev_res});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) begin
          check("result", {bus.Bout, bus.D}, exp_q.pop_front());
          n_res++;
        end else
          check("extra_result", exp_q.size(), 1);
      end
      prev_ov   = bus.out_valid;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_res  = {bus.Bout, bus.D};
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(posedge clk); #1;
    bus.A = a; bus.B = b; bus.Bin = bin; bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) return;
    end
    check("valid_timeout", bus.out_valid, 1);
  endtask

  initial begin
    int res0;
    logic saw;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_D", bus.D, 0);
    check("rst_Bout", bus.Bout, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    // 1: basic
    ordy_fix = 1'b1;
    send(4'd9, 4'd3, 1'b0);
    wait_valid();
    check("t1_D", bus.D, 6);
    check("t1_Bout", bus.Bout, 0);
    check("t1_busy", bus.busy, 1);
    check("t1_in_ready_done", bus.in_ready, 0);

    // 2: negative result and borrow-in wrap
    send(4'd3, 4'd9, 1'b0);
    wait_valid();
    check("t2a_D", bus.D, 4'hA);
    check("t2a_Bout", bus.Bout, 1);
    send(4'd0, 4'd0, 1'b1);
    wait_valid();
    check("t2b_D", bus.D, 4'hF);
    check("t2b_Bout", bus.Bout, 1);

    // 3: backpressure with ignored input pulses
    ordy_fix = 1'b0;
    send(4'd5, 4'd7, 1'b0);
    wait_valid();
    check("t3_D", bus.D, 4'hE);
    check("t3_Bout", bus.Bout, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.A = W'(i + 1); bus.B = W'(i);
      @(negedge clk);
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_in_ready", bus.in_ready, 0);
      check("t3_hold_D", bus.D, 4'hE);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; ordy_fix = 1'b1;
    @(negedge clk);
    check("t3_pre_hs_valid", bus.out_valid, 1);
    @(negedge clk);
    check("t3_post_valid", bus.out_valid, 0);
    check("t3_post_in_ready", bus.in_ready, 1);
    check("t3_post_busy", bus.busy, 0);
    check("t3_post_D_kept", bus.D, 4'hE);

    // 4: reset two cycles into RUN aborts the op
    send(4'd6, 4'd2, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t4_in_ready_rst", bus.in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t4_in_ready", bus.in_ready, 1);
    check("t4_out_valid", bus.out_valid, 0);
    check("t4_D", bus.D, 0);
    check("t4_busy", bus.busy, 0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw = saw | bus.out_valid;
    end
    check("t4_no_valid", saw, 0);
    send(4'd15, 4'd1, 1'b0);
    wait_valid();
    check("t4_D_next", bus.D, 14);
    check("t4_Bout_next", bus.Bout, 0);

    // 5: exhaustive under random backpressure
    @(negedge clk);
    rnd_en = 1'b1;
    res0 = n_res;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          send(W'(a), W'(b), 1'(c));
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("t5_drained", exp_q.size(), 0);
    check("t5_count", n_res - res0, 512);
    rnd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
